// File: rtl/cpu_ctrl_pkg.sv
// Control codes and FSM encoding shared by the EX/MEM, MEM/WB and decoder blocks.
package cpu_ctrl_pkg;

   localparam logic [3:0] CTL_LW  = 4'b0110;
   localparam logic [3:0] CTL_SW  = 4'b0111;
   localparam logic [3:0] CTL_BR  = 4'b1000;
   localparam logic [3:0] CTL_NOP = 4'b1111;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_BUSY = 1'b1;

   function automatic logic is_mem_op(input logic [3:0] ctl);
      return (ctl == CTL_LW) || (ctl == CTL_SW);
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Variable-latency req/ack data-memory port between the EX/MEM stage and data memory.
interface ex_mem_stage_if;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_ack_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      output dmem_ack_i, dmem_rdata_i
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a data-memory access controller that stalls the
// front end while a load/store is outstanding and feeds NOP bubbles to MEM/WB.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | latched entry is not a memory op, or its access completed
// BUSY    | request outstanding, waiting for ack or timeout
module ex_mem_stage
   import cpu_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  control_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] wrData_i,
   input  logic [4:0]  RDaddr_i,
   output logic [3:0]  control_o,
   output logic [31:0] memData_o,
   output logic [31:0] ALUResult_o,
   output logic [4:0]  RDaddr_o,
   output logic        stall_o,
   output logic        err_o,
   ex_mem_stage_if.master dmem
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [3:0]  ctl_q, ctl_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] wd_q, wd_d;
   logic [4:0]  rd_q, rd_d;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;

   logic busy, ack, timeout, stall, misaligned;

   always_comb begin
      busy       = (state_q == ST_BUSY);
      ack        = busy && dmem.dmem_ack_i;
      timeout    = busy && !ack && (cnt_q == WAIT_LAST);
      stall      = busy && !ack && !timeout;
      misaligned = is_mem_op(control_i) && (ALUResult_i[1:0] != 2'b00);

      ctl_d   = ctl_q;
      alu_d   = alu_q;
      wd_d    = wd_q;
      rd_d    = rd_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q || timeout;

      if (!stall) begin
         // A misaligned access is squashed to a NOP and never reaches memory.
         ctl_d   = misaligned ? CTL_NOP : control_i;
         alu_d   = ALUResult_i;
         wd_d    = wrData_i;
         rd_d    = RDaddr_i;
         state_d = (is_mem_op(control_i) && !misaligned) ? ST_BUSY : ST_IDLE;
         cnt_d   = 8'd0;
         if (misaligned) err_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctl_q   <= CTL_NOP;
         alu_q   <= 32'd0;
         wd_q    <= 32'd0;
         rd_q    <= 5'd0;
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         ctl_q   <= ctl_d;
         alu_q   <= alu_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Waiting or timed-out cycles present a bubble; the ack cycle forwards the entry.
   assign control_o   = (busy && !ack) ? CTL_NOP : ctl_q;
   assign memData_o   = ack ? dmem.dmem_rdata_i : 32'd0;
   assign ALUResult_o = alu_q;
   assign RDaddr_o    = rd_q;
   assign stall_o     = stall;
   assign err_o       = err_q;

   assign dmem.dmem_req_o   = busy;
   assign dmem.dmem_we_o    = busy && (ctl_q == CTL_SW);
   assign dmem.dmem_addr_o  = {alu_q[31:2], 2'b00};
   assign dmem.dmem_wdata_o = wd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: expected MEM/WB entries are queued when an
// instruction is driven and compared when the stage presents it.
module tb_ex_mem_stage;
   import cpu_ctrl_pkg::*;

   logic        clk, rst;
   logic [3:0]  control_i;
   logic [31:0] ALUResult_i, wrData_i;
   logic [4:0]  RDaddr_i;
   logic [3:0]  control_o;
   logic [31:0] memData_o, ALUResult_o;
   logic [4:0]  RDaddr_o;
   logic        stall_o, err_o;

   ex_mem_stage_if dmem_bus ();

   ex_mem_stage #(.MAX_WAIT(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .control_i   (control_i),
      .ALUResult_i (ALUResult_i),
      .wrData_i    (wrData_i),
      .RDaddr_i    (RDaddr_i),
      .control_o   (control_o),
      .memData_o   (memData_o),
      .ALUResult_o (ALUResult_o),
      .RDaddr_o    (RDaddr_o),
      .stall_o     (stall_o),
      .err_o       (err_o),
      .dmem        (dmem_bus.master)
   );

   typedef struct packed {
      logic [3:0]  ctl;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] mem;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w,
                        input logic [4:0] r);
      control_i   = c;
      ALUResult_i = a;
      wrData_i    = w;
      RDaddr_i    = r;
   endtask

   task automatic mem_resp(input logic a, input logic [31:0] d);
      dmem_bus.dmem_ack_i   = a;
      dmem_bus.dmem_rdata_i = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_ctl"}, {28'd0, control_o}, {28'd0, e.ctl});
         chk({tag, "_alu"}, ALUResult_o, e.alu);
         chk({tag, "_rd"},  {27'd0, RDaddr_o}, {27'd0, e.rd});
         chk({tag, "_mem"}, memData_o, e.mem);
      end
   endtask

   task automatic chk_bus(input string tag, input logic req, input logic stall,
                          input logic [3:0] ctl);
      chk({tag, "_req"},   {31'd0, dmem_bus.dmem_req_o}, {31'd0, req});
      chk({tag, "_stall"}, {31'd0, stall_o}, {31'd0, stall});
      chk({tag, "_ctl"},   {28'd0, control_o}, {28'd0, ctl});
   endtask

   initial begin
      rst = 1'b1;
      drive(CTL_NOP, 32'd0, 32'd0, 5'd0);
      mem_resp(1'b0, 32'd0);
      tick(); tick();
      settle();
      chk_bus("rst", 1'b0, 1'b0, CTL_NOP);
      chk("rst_alu", ALUResult_o, 32'd0);
      chk("rst_rd", {27'd0, RDaddr_o}, 32'd0);
      chk("rst_mem", memData_o, 32'd0);
      chk("rst_we", {31'd0, dmem_bus.dmem_we_o}, 32'd0);
      chk("rst_addr", dmem_bus.dmem_addr_o, 32'd0);
      chk("rst_wdata", dmem_bus.dmem_wdata_o, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      tick();
      rst = 1'b0;

      // ALU op: one-cycle latency
      drive(4'b0010, 32'h1234, 32'd0, 5'd5);
      sb.push_back('{4'b0010, 32'h1234, 5'd5, 32'd0});
      tick();
      drive(CTL_NOP, 32'd0, 32'd0, 5'd0);
      settle();
      pop_cmp("alu");
      chk_bus("alu", 1'b0, 1'b0, 4'b0010);

      // lw 0x40, ack in the third request cycle
      drive(CTL_LW, 32'h40, 32'd0, 5'd7);
      sb.push_back('{CTL_LW, 32'h40, 5'd7, 32'hDEADBEEF});
      tick();
      drive(CTL_NOP, 32'd0, 32'd0, 5'd0);
      for (int i = 0; i < 2; i++) begin
         settle();
         chk_bus("lw_wait", 1'b1, 1'b1, CTL_NOP);
         chk("lw_addr", dmem_bus.dmem_addr_o, 32'h40);
         chk("lw_we", {31'd0, dmem_bus.dmem_we_o}, 32'd0);
         tick();
      end
      mem_resp(1'b1, 32'hDEADBEEF);
      settle();
      chk("lw_ack_stall", {31'd0, stall_o}, 32'd0);
      pop_cmp("lw_ack");
      tick();
      mem_resp(1'b0, 32'd0);
      settle();
      chk_bus("lw_done", 1'b0, 1'b0, CTL_NOP);

      // sw 0x44 then back-to-back zero-wait lw 0x48
      drive(CTL_SW, 32'h44, 32'hCAFEF00D, 5'd0);
      sb.push_back('{CTL_SW, 32'h44, 5'd0, 32'd0});
      tick();
      drive(CTL_LW, 32'h48, 32'd0, 5'd9);
      for (int i = 0; i < 2; i++) begin
         settle();
         chk_bus("sw_wait", 1'b1, 1'b1, CTL_NOP);
         chk("sw_we", {31'd0, dmem_bus.dmem_we_o}, 32'd1);
         chk("sw_addr", dmem_bus.dmem_addr_o, 32'h44);
         chk("sw_wdata", dmem_bus.dmem_wdata_o, 32'hCAFEF00D);
         tick();
      end
      mem_resp(1'b1, 32'd0);
      settle();
      chk("sw_ack_stall", {31'd0, stall_o}, 32'd0);
      pop_cmp("sw_ack");
      sb.push_back('{CTL_LW, 32'h48, 5'd9, 32'h11112222});
      tick();
      drive(CTL_NOP, 32'd0, 32'd0, 5'd0);
      mem_resp(1'b1, 32'h11112222);
      settle();
      chk("b2b_req", {31'd0, dmem_bus.dmem_req_o}, 32'd1);
      chk("b2b_addr", dmem_bus.dmem_addr_o, 32'h48);
      chk("b2b_we", {31'd0, dmem_bus.dmem_we_o}, 32'd0);
      chk("b2b_stall", {31'd0, stall_o}, 32'd0);
      pop_cmp("b2b_lw");
      tick();
      mem_resp(1'b0, 32'd0);
      settle();
      chk_bus("b2b_done", 1'b0, 1'b0, CTL_NOP);

      // misaligned lw 0x42: squashed, sticky error
      drive(CTL_LW, 32'h42, 32'd0, 5'd3);
      tick();
      drive(CTL_NOP, 32'd0, 32'd0, 5'd0);
      settle();
      chk_bus("mis", 1'b0, 1'b0, CTL_NOP);
      chk("mis_err", {31'd0, err_o}, 32'd1);
      tick(); tick();
      settle();
      chk("mis_err_sticky", {31'd0, err_o}, 32'd1);

      // reset clears error
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk("rst2_err", {31'd0, err_o}, 32'd0);
      tick();

      // timeout: no ack, MAX_WAIT=4
      drive(CTL_LW, 32'h50, 32'd0, 5'd4);
      tick();
      drive(CTL_NOP, 32'd0, 32'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk_bus("to_wait", 1'b1, 1'b1, CTL_NOP);
         chk("to_err_pre", {31'd0, err_o}, 32'd0);
         tick();
      end
      settle();
      chk_bus("to_last", 1'b1, 1'b0, CTL_NOP);
      tick();
      mem_resp(1'b1, 32'h55AA55AA);
      settle();
      chk_bus("to_late_ack", 1'b0, 1'b0, CTL_NOP);
      chk("to_late_mem", memData_o, 32'd0);
      chk("to_err", {31'd0, err_o}, 32'd1);
      tick();
      mem_resp(1'b0, 32'd0);

      // reset during BUSY
      drive(CTL_LW, 32'h60, 32'd0, 5'd6);
      tick();
      drive(CTL_NOP, 32'd0, 32'd0, 5'd0);
      settle();
      chk("rb_req", {31'd0, dmem_bus.dmem_req_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk_bus("rb_async", 1'b0, 1'b0, CTL_NOP);
      tick();
      rst = 1'b0;
      mem_resp(1'b1, 32'h12345678);
      settle();
      chk_bus("rb_after", 1'b0, 1'b0, CTL_NOP);
      chk("rb_alu", ALUResult_o, 32'd0);
      chk("rb_mem", memData_o, 32'd0);
      tick();
      mem_resp(1'b0, 32'd0);
      settle();
      chk("rb_req2", {31'd0, dmem_bus.dmem_req_o}, 32'd0);

      chk("sb_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
